reg_pair_write_arbiter: RTL and testbench

- Shares write access to the two-register 8-bit pair (D1/D2 in, Q1/Q2 out) among NREQ requesters.
- Round-robin arbitration; one write in flight at a time.
- Holds the pair's D-side values, then waits for the pair's capture edge before reading Q back.
- Acknowledges the winner with a readback check flag.

---
 rtl/reg_pair_write_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_reg_pair_write_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pair_write_arbiter.sv
// reg_pair_write_arbiter: round-robin write arbiter for a two-register
// DW-bit pair. One write in flight at a time. The winner's data is driven
// onto D1 or D2, the pair's capture edge is waited out, and Q is read back
// before the winner is acknowledged with a readback-mismatch flag.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req[NREQ]         level write requests, held until ack
//   req_sel[NREQ]     target per requester: 0 = register 1, 1 = register 2
//   req_data          per-requester data, slice i = [i*DW +: DW]
//   gnt[NREQ]         one-hot current owner, zero when idle
//   ack[NREQ]         one-hot one-cycle completion pulse
//   err               readback mismatch, coincident with ack
//   busy              high whenever not idle
//   d1, d2            drive the pair's D inputs
//   q1, q2            the pair's Q outputs
module reg_pair_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_sel,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic               busy,
    output logic [DW-1:0]      d1,
    output logic [DW-1:0]      d2,
    input  logic [DW-1:0]      q1,
    input  logic [DW-1:0]      q2
);

    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_win;
    logic              r_sel;
    logic [DW-1:0]     r_data;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_err;
    logic [DW-1:0]     r_d1;
    logic [DW-1:0]     r_d2;

    logic [NREQ-1:0]   w_elig;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [PW-1:0]     w_off;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_win;
    logic              w_found;
    logic              w_wsel;
    logic [DW-1:0]     w_wdata;
    logic [PW:0]       w_pinc;
    logic [PW-1:0]     w_ptr_nxt;
    logic [DW-1:0]     w_rb;
    logic              w_mis;
    logic              w_busy;

    // A requester whose ack is high this cycle is masked so a request
    // still held during its ack cycle is not granted a second time.
    // Eligible requests are rotated so bit 0 corresponds to r_ptr; the
    // lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        w_elig  = req & ~r_ack;
        w_found = |w_elig;
        w_dbl   = {w_elig, w_elig} >> r_ptr;
        w_rot   = w_dbl[NREQ-1:0];
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
        end
        w_win = w_sum[PW-1:0];
    end

    // Per-winner target and data.
    always_comb begin
        w_wsel  = 1'b0;
        w_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == PW'(k)) begin
                w_wsel  = req_sel[k];
                w_wdata = req_data[k*DW +: DW];
            end
        end
    end

    // Pointer moves to the requester after the one just served.
    always_comb begin
        w_pinc = {1'b0, r_win} + 1'b1;
        if (w_pinc == NREQ_W) begin
            w_pinc = '0;
        end
        w_ptr_nxt = w_pinc[PW-1:0];
    end

    assign w_rb  = r_sel ? q2 : q1;
    assign w_mis = (w_rb != r_data);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = w_found ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  w_next = S_CHECK;
            S_CHECK: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // Registered datapath: latches, D outputs, grant/ack/err, pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_win  <= '0;
            r_sel  <= 1'b0;
            r_data <= '0;
            r_gnt  <= '0;
            r_ack  <= '0;
            r_err  <= 1'b0;
            r_d1   <= '0;
            r_d2   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win  <= w_win;
                        r_sel  <= w_wsel;
                        r_data <= w_wdata;
                        r_gnt  <= NREQ'(1) << w_win;
                    end
                end
                S_LOAD: begin
                    if (r_sel) begin
                        r_d2 <= r_data;
                    end else begin
                        r_d1 <= r_data;
                    end
                end
                S_WAIT: begin
                end
                S_CHECK: begin
                    r_ack <= r_gnt;
                    r_err <= w_mis;
                    r_gnt <= '0;
                    r_ptr <= w_ptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign err  = r_err;
    assign busy = w_busy;
    assign d1   = r_d1;
    assign d2   = r_d2;

endmodule

// File: tb/tb_reg_pair_write_arbiter.sv
// tb_reg_pair_write_arbiter: directed bench for reg_pair_write_arbiter
// with a behavioural model of the two-register pair on d1/d2 -> q1/q2.
module tb_reg_pair_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_sel;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic               busy;
    logic [DW-1:0]      d1;
    logic [DW-1:0]      d2;
    logic [DW-1:0]      q1;
    logic [DW-1:0]      q2;
    logic [DW-1:0]      pq1;
    logic [DW-1:0]      pq2;
    logic               force_q2;

    int n_chk;
    int n_err;

    reg_pair_write_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_sel  (req_sel),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .d1       (d1),
        .d2       (d2),
        .q1       (q1),
        .q2       (q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register pair model, sharing clock and reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pq1 <= '0;
            pq2 <= '0;
        end else begin
            pq1 <= d1;
            pq2 <= d2;
        end
    end

    assign q1 = pq1;
    assign q2 = force_q2 ? '0 : pq2;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int i, input logic s,
                           input logic [DW-1:0] d);
        req_sel[i] = s;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    int rec_i[6];
    int rec_t[6];
    int nack;
    int cyc;
    int idx;
    logic [NREQ-1:0] last;
    logic [NREQ-1:0] win_or;
    logic [NREQ-1:0] ack_seen;

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b1;
        req      = '0;
        req_sel  = '0;
        req_data = '0;
        force_q2 = 1'b0;
        ticks(2);
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_d1", 32'(d1), 32'h0);
        check("rst_d2", 32'(d2), 32'h0);

        // Single write
        set_req(0, 1'b0, 8'hA5);
        req = 4'b0001;
        tick();
        check("s_gnt", 32'(gnt), 32'h1);
        check("s_busy", 32'(busy), 32'h1);
        check("s_d1_e0", 32'(d1), 32'h0);
        tick();
        check("s_d1_e1", 32'(d1), 32'hA5);
        check("s_ack_e1", 32'(ack), 32'h0);
        tick();
        check("s_q1_e2", 32'(q1), 32'hA5);
        check("s_ack_e2", 32'(ack), 32'h0);
        tick();
        check("s_ack", 32'(ack), 32'h1);
        check("s_err", 32'(err), 32'h0);
        check("s_d2", 32'(d2), 32'h0);
        check("s_gnt0", 32'(gnt), 32'h0);
        req = '0;
        tick();
        check("s_ack_clr", 32'(ack), 32'h0);

        // Simultaneous requests from ptr=0
        do_reset();
        set_req(0, 1'b1, 8'h3C);
        set_req(2, 1'b0, 8'h81);
        req = 4'b0101;
        tick();
        check("m_gnt0", 32'(gnt), 32'h1);
        ticks(3);
        check("m_ack0", 32'(ack), 32'h1);
        check("m_d2", 32'(d2), 32'h3C);
        req = 4'b0100;
        tick();
        check("m_gnt2", 32'(gnt), 32'h4);
        check("m_ack0clr", 32'(ack), 32'h0);
        ticks(3);
        check("m_ack2", 32'(ack), 32'h4);
        check("m_d1", 32'(d1), 32'h81);
        check("m_d2b", 32'(d2), 32'h3C);
        // ptr=3: requesters 0 and 3 contend, 3 wins
        set_req(3, 1'b0, 8'h11);
        set_req(0, 1'b0, 8'h22);
        req = 4'b1001;
        tick();
        check("m_gnt3", 32'(gnt), 32'h8);
        ticks(3);
        check("m_ack3", 32'(ack), 32'h8);
        req = 4'b0001;
        tick();
        check("m_gnt0b", 32'(gnt), 32'h1);
        ticks(3);
        check("m_ack0b", 32'(ack), 32'h1);
        check("m_d1b", 32'(d1), 32'h22);
        req = '0;
        tick();

        // Fairness under continuous contention
        do_reset();
        set_req(0, 1'b0, 8'h10);
        set_req(1, 1'b1, 8'h21);
        set_req(2, 1'b0, 8'h32);
        set_req(3, 1'b1, 8'h43);
        req  = 4'hF;
        last = '0;
        nack = 0;
        cyc  = 0;
        while (nack < 6 && cyc < 80) begin
            tick();
            cyc++;
            if (ack != 0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
                rec_i[nack] = idx;
                rec_t[nack] = cyc;
                nack++;
            end
            req  = 4'hF & ~last;
            last = ack;
        end
        check("f_count", 32'(nack), 32'd6);
        for (int j = 0; j < nack; j++) begin
            check($sformatf("f_order%0d", j), 32'(rec_i[j]), 32'(j % 4));
            if (j > 0)
                check($sformatf("f_gap%0d", j),
                      32'(rec_t[j] - rec_t[j-1]), 32'd4);
        end
        for (int j = 0; j + 3 < nack; j++) begin
            win_or = '0;
            for (int k = 0; k < 4; k++) win_or[rec_i[j+k]] = 1'b1;
            check($sformatf("f_window%0d", j), 32'(win_or), 32'hF);
        end
        req = '0;
        for (int i = 0; i < 10 && busy; i++) tick();
        tick();

        // Readback mismatch on register 2
        set_req(1, 1'b1, 8'h7E);
        force_q2 = 1'b1;
        req = 4'b0010;
        tick();
        check("x_gnt", 32'(gnt), 32'h2);
        ticks(3);
        check("x_ack", 32'(ack), 32'h2);
        check("x_err", 32'(err), 32'h1);
        check("x_d2", 32'(d2), 32'h7E);
        req = '0;
        force_q2 = 1'b0;
        tick();
        check("x_err_clr", 32'(err), 32'h0);
        check("x_ack_clr", 32'(ack), 32'h0);

        // Reset while in WAIT
        set_req(2, 1'b0, 8'h55);
        req = 4'b0100;
        ticks(2);
        check("r_d1_wait", 32'(d1), 32'h55);
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        check("r_d1", 32'(d1), 32'h0);
        check("r_d2", 32'(d2), 32'h0);
        check("r_busy", 32'(busy), 32'h0);
        check("r_gnt", 32'(gnt), 32'h0);
        ack_seen = '0;
        win_or   = '0;
        for (int i = 0; i < 5; i++) begin
            ack_seen |= ack;
            win_or[0] = win_or[0] | err;
            tick();
        end
        check("r_no_ack", 32'(ack_seen), 32'h0);
        check("r_no_err", 32'(win_or), 32'h0);
        // ptr cleared: requesters 1 and 3 contend, 1 wins
        set_req(1, 1'b0, 8'h66);
        set_req(3, 1'b1, 8'h99);
        req = 4'b1010;
        tick();
        check("r_gnt1", 32'(gnt), 32'h2);
        ticks(3);
        check("r_ack1", 32'(ack), 32'h2);
        check("r_err1", 32'(err), 32'h0);
        check("r_d1new", 32'(d1), 32'h66);
        req = 4'b1000;
        tick();
        check("r_gnt3", 32'(gnt), 32'h8);
        ticks(3);
        check("r_ack3", 32'(ack), 32'h8);
        check("r_d2new", 32'(d2), 32'h99);
        req = '0;
        tick();

        // Ack masking: req held through ack cycle, then dropped
        set_req(1, 1'b0, 8'h5A);
        req = 4'b0010;
        tick();
        check("k_gnt", 32'(gnt), 32'h2);
        ticks(3);
        check("k_ack", 32'(ack), 32'h2);
        tick();
        check("k_nogrant", 32'(gnt), 32'h0);
        check("k_idle", 32'(busy), 32'h0);
        req = '0;
        tick();
        check("k_nogrant2", 32'(gnt), 32'h0);

        // Ack masking: req held two cycles past ack, regranted once
        req = 4'b0010;
        tick();
        ticks(3);
        check("k2_ack", 32'(ack), 32'h2);
        tick();
        check("k2_masked", 32'(gnt), 32'h0);
        tick();
        check("k2_regrant", 32'(gnt), 32'h2);
        req = '0;
        ticks(3);
        check("k2_ack2", 32'(ack), 32'h2);
        tick();
        check("k2_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
